cdc_data_checker: RTL and testbench

CDC_DATA_CHECKER -- requirements
Module: cdc_data_checker

---
 rtl/cdc_data_checker.sv | 198 +++++++++++++++++++
 tb/tb_cdc_data_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_data_checker.sv
// rtl/cdc_data_checker.sv - per-channel sequence checker for CDC handshake destination data
//
// Purpose: checks that each destination channel receives an incrementing or
// LFSR payload sequence, detecting mismatches and idle timeouts.
// Ports:
//   dest_clk, dest_reset        clock and synchronous active-high reset
//   enable                      accept strobes; when low all channel state holds
//   clear                       zero counters, sticky flags and first-error capture
//   dest_strobe, dest_data      per-channel data-valid pulse and payload
//   xfer_count, error_count     saturating totals across all channels
//   locked, err_sticky,
//   timeout_sticky              per-channel status
//   first_err_*                 capture of the first mismatch since reset/clear
module cdc_data_checker #(
    parameter int          NUM_CH      = 4,
    parameter int          DATA_W      = 32,
    parameter int          CNT_W       = 32,
    parameter int          MODE        = 0,
    parameter logic [31:0] POLY        = 32'h8020_0003,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic                     dest_clk,
    input  logic                     dest_reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        dest_strobe,
    input  logic [NUM_CH*DATA_W-1:0] dest_data,
    output logic [CNT_W-1:0]         xfer_count,
    output logic [CNT_W-1:0]         error_count,
    output logic [NUM_CH-1:0]        locked,
    output logic [NUM_CH-1:0]        err_sticky,
    output logic [NUM_CH-1:0]        timeout_sticky,
    output logic                     first_err_valid,
    output logic [3:0]               first_err_ch,
    output logic [DATA_W-1:0]        first_err_exp,
    output logic [DATA_W-1:0]        first_err_got
);

    typedef enum logic {WAIT_SYNC = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [DATA_W-1:0] POLY_T = DATA_W'(POLY);
    // Gap counter only needs to reach TIMEOUT_CYC.
    localparam int GAP_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [GAP_W-1:0] TO_VAL = GAP_W'(TIMEOUT_CYC);

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [DATA_W-1:0] exp_q   [NUM_CH];
    logic [DATA_W-1:0] exp_d   [NUM_CH];
    logic [GAP_W-1:0]  gap_q   [NUM_CH];
    logic [GAP_W-1:0]  gap_d   [NUM_CH];

    logic [CNT_W-1:0]  xfer_count_q, xfer_count_d;
    logic [CNT_W-1:0]  error_count_q, error_count_d;
    logic [NUM_CH-1:0] err_sticky_q, err_sticky_d;
    logic [NUM_CH-1:0] timeout_sticky_q, timeout_sticky_d;
    logic              first_err_valid_q, first_err_valid_d;
    logic [3:0]        first_err_ch_q, first_err_ch_d;
    logic [DATA_W-1:0] first_err_exp_q, first_err_exp_d;
    logic [DATA_W-1:0] first_err_got_q, first_err_got_d;

    logic [4:0]        xfer_inc;
    logic [4:0]        err_inc;
    logic [DATA_W-1:0] ch_data;
    logic [GAP_W-1:0]  gap_inc;
    logic              accepted;

    function automatic logic [DATA_W-1:0] next_val(input logic [DATA_W-1:0] x);
        if (MODE == 1) begin
            return (x << 1) ^ (x[DATA_W-1] ? POLY_T : '0);
        end
        return x + DATA_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [4:0] b);
        logic [CNT_W+4:0] s;
        s = {5'd0, a} + {{CNT_W{1'b0}}, b};
        if (s[CNT_W+4:CNT_W] != 5'd0) begin
            return '1;
        end
        return s[CNT_W-1:0];
    endfunction

    always_comb begin
        state_d           = state_q;
        exp_d             = exp_q;
        gap_d             = gap_q;
        err_sticky_d      = err_sticky_q;
        timeout_sticky_d  = timeout_sticky_q;
        first_err_valid_d = first_err_valid_q;
        first_err_ch_d    = first_err_ch_q;
        first_err_exp_d   = first_err_exp_q;
        first_err_got_d   = first_err_got_q;
        xfer_inc          = 5'd0;
        err_inc           = 5'd0;
        ch_data           = '0;
        gap_inc           = '0;
        accepted          = 1'b0;

        for (int i = 0; i < NUM_CH; i++) begin
            ch_data  = dest_data[i*DATA_W +: DATA_W];
            accepted = enable & dest_strobe[i];
            gap_inc  = gap_q[i] + GAP_W'(1);
            if (accepted) begin
                xfer_inc = xfer_inc + 5'd1;
                gap_d[i] = '0;
                // On a match next(data) equals next(expected), so both the
                // locked-match and resync cases load next(data).
                exp_d[i] = next_val(ch_data);
                if (state_q[i] == WAIT_SYNC) begin
                    state_d[i] = LOCKED;
                end else if (ch_data != exp_q[i]) begin
                    err_inc         = err_inc + 5'd1;
                    err_sticky_d[i] = 1'b1;
                    // Ascending loop plus the valid flag makes the lowest channel win.
                    if (!first_err_valid_d) begin
                        first_err_valid_d = 1'b1;
                        first_err_ch_d    = 4'(i);
                        first_err_exp_d   = exp_q[i];
                        first_err_got_d   = ch_data;
                    end
                end
            end else if (enable && state_q[i] == LOCKED && TIMEOUT_CYC != 0) begin
                if (gap_inc == TO_VAL) begin
                    err_inc             = err_inc + 5'd1;
                    timeout_sticky_d[i] = 1'b1;
                    gap_d[i]            = '0;
                    state_d[i]          = WAIT_SYNC;
                end else begin
                    gap_d[i] = gap_inc;
                end
            end
        end

        // Clear wipes reporting state only; channel tracking continues.
        if (clear) begin
            xfer_count_d      = '0;
            error_count_d     = '0;
            err_sticky_d      = '0;
            timeout_sticky_d  = '0;
            first_err_valid_d = 1'b0;
            first_err_ch_d    = 4'd0;
            first_err_exp_d   = '0;
            first_err_got_d   = '0;
        end else begin
            xfer_count_d  = sat_add(xfer_count_q, xfer_inc);
            error_count_d = sat_add(error_count_q, err_inc);
        end
    end

    always_ff @(posedge dest_clk) begin
        if (dest_reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= WAIT_SYNC;
                exp_q[i]   <= '0;
                gap_q[i]   <= '0;
            end
            xfer_count_q      <= '0;
            error_count_q     <= '0;
            err_sticky_q      <= '0;
            timeout_sticky_q  <= '0;
            first_err_valid_q <= 1'b0;
            first_err_ch_q    <= 4'd0;
            first_err_exp_q   <= '0;
            first_err_got_q   <= '0;
        end else begin
            state_q           <= state_d;
            exp_q             <= exp_d;
            gap_q             <= gap_d;
            xfer_count_q      <= xfer_count_d;
            error_count_q     <= error_count_d;
            err_sticky_q      <= err_sticky_d;
            timeout_sticky_q  <= timeout_sticky_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_ch_q    <= first_err_ch_d;
            first_err_exp_q   <= first_err_exp_d;
            first_err_got_q   <= first_err_got_d;
        end
    end

    always_comb begin
        locked = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            locked[i] = (state_q[i] == LOCKED);
        end
    end

    assign xfer_count      = xfer_count_q;
    assign error_count     = error_count_q;
    assign err_sticky      = err_sticky_q;
    assign timeout_sticky  = timeout_sticky_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_ch    = first_err_ch_q;
    assign first_err_exp   = first_err_exp_q;
    assign first_err_got   = first_err_got_q;

endmodule

// File: tb/tb_cdc_data_checker.sv
// tb/tb_cdc_data_checker.sv - self-checking bench for cdc_data_checker
module tb_cdc_data_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  strobe0 = '0;
    logic [31:0] data0 = '0;
    logic [0:0]  strobe1 = '0;
    logic [7:0]  data1 = '0;

    logic [3:0] x0, e0;
    logic [3:0] lk0, es0, ts0;
    logic       fv0;
    logic [3:0] fch0;
    logic [7:0] fexp0, fgot0;

    logic [7:0] x1, e1;
    logic [0:0] lk1, es1, ts1;
    logic       fv1;
    logic [3:0] fch1;
    logic [7:0] fexp1, fgot1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cdc_data_checker #(.NUM_CH(4), .DATA_W(8), .CNT_W(4), .MODE(0), .TIMEOUT_CYC(8)) u0 (
        .dest_clk(clk), .dest_reset(rst), .enable(en), .clear(clr),
        .dest_strobe(strobe0), .dest_data(data0),
        .xfer_count(x0), .error_count(e0), .locked(lk0), .err_sticky(es0),
        .timeout_sticky(ts0), .first_err_valid(fv0), .first_err_ch(fch0),
        .first_err_exp(fexp0), .first_err_got(fgot0));

    cdc_data_checker #(.NUM_CH(1), .DATA_W(8), .CNT_W(8), .MODE(1), .TIMEOUT_CYC(0)) u1 (
        .dest_clk(clk), .dest_reset(rst), .enable(en), .clear(clr),
        .dest_strobe(strobe1), .dest_data(data1),
        .xfer_count(x1), .error_count(e1), .locked(lk1), .err_sticky(es1),
        .timeout_sticky(ts1), .first_err_valid(fv1), .first_err_ch(fch1),
        .first_err_exp(fexp1), .first_err_got(fgot1));

    // Specification-level model of u0 (4 channels, 8-bit increment, timeout 8, 4-bit counters).
    int m_xfer, m_err, m_fch, m_fexp, m_fgot;
    int m_exp [4];
    int m_gap [4];
    bit m_lock [4];
    bit [3:0] m_es, m_ts;
    bit m_fv;

    task automatic model_step();
        int nx, ne, d;
        if (rst) begin
            m_xfer = 0; m_err = 0; m_es = 0; m_ts = 0;
            m_fv = 0; m_fch = 0; m_fexp = 0; m_fgot = 0;
            for (int c = 0; c < 4; c++) begin
                m_lock[c] = 0; m_exp[c] = 0; m_gap[c] = 0;
            end
            return;
        end
        nx = 0; ne = 0;
        for (int c = 0; c < 4; c++) begin
            d = int'((data0 >> (8 * c)) & 32'hFF);
            if (en && strobe0[c]) begin
                nx++;
                if (m_lock[c] && d != m_exp[c]) begin
                    ne++;
                    m_es[c] = 1;
                    if (!m_fv) begin
                        m_fv = 1; m_fch = c; m_fexp = m_exp[c]; m_fgot = d;
                    end
                end
                m_lock[c] = 1;
                m_exp[c] = (d + 1) % 256;
                m_gap[c] = 0;
            end else if (en && m_lock[c]) begin
                m_gap[c]++;
                if (m_gap[c] == 8) begin
                    ne++;
                    m_ts[c] = 1;
                    m_gap[c] = 0;
                    m_lock[c] = 0;
                end
            end
        end
        if (clr) begin
            m_xfer = 0; m_err = 0; m_es = 0; m_ts = 0;
            m_fv = 0; m_fch = 0; m_fexp = 0; m_fgot = 0;
        end else begin
            m_xfer = (m_xfer + nx > 15) ? 15 : m_xfer + nx;
            m_err  = (m_err + ne > 15) ? 15 : m_err + ne;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        bit [3:0] ml;
        @(negedge clk);
        for (int c = 0; c < 4; c++) ml[c] = m_lock[c];
        chk("cyc_xfer", 64'(x0), 64'(m_xfer));
        chk("cyc_err", 64'(e0), 64'(m_err));
        chk("cyc_locked", 64'(lk0), 64'(ml));
        chk("cyc_err_sticky", 64'(es0), 64'(m_es));
        chk("cyc_to_sticky", 64'(ts0), 64'(m_ts));
        chk("cyc_fev", 64'(fv0), 64'(m_fv));
        chk("cyc_fch", 64'(fch0), 64'(m_fch));
        chk("cyc_fexp", 64'(fexp0), 64'(m_fexp));
        chk("cyc_fgot", 64'(fgot0), 64'(m_fgot));
    end

    function automatic logic [31:0] pk(input int ch, input int v);
        return 32'(v & 255) << (8 * ch);
    endfunction

    task automatic drive(input logic [3:0] s, input logic [31:0] d);
        strobe0 = s; data0 = d;
        @(negedge clk);
        strobe0 = '0;
    endtask

    task automatic drive1(input logic [7:0] d);
        strobe1 = 1'b1; data1 = d;
        @(negedge clk);
        strobe1 = 1'b0;
    endtask

    task automatic idle(input int n);
        strobe0 = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] lfsr_seq [11];
        lfsr_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h03, 8'h06, 8'h0C};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_xfer", 64'(x0), 0);
        chk("reset_locked", 64'(lk0), 0);
        chk("reset_fev", 64'(fv0), 0);

        // Basic increment lock on ch0.
        drive(4'b0001, pk(0, 5)); drive(4'b0001, pk(0, 6));
        drive(4'b0001, pk(0, 7)); drive(4'b0001, pk(0, 8));
        chk("inc_xfer", 64'(x0), 4);
        chk("inc_err", 64'(e0), 0);
        chk("inc_locked0", 64'(lk0[0]), 1);

        // Mismatch on ch1 with first-error capture.
        do_reset();
        drive(4'b0010, pk(1, 10)); drive(4'b0010, pk(1, 11));
        drive(4'b0010, pk(1, 99)); drive(4'b0010, pk(1, 100));
        chk("mis_err", 64'(e0), 1);
        chk("mis_sticky1", 64'(es0[1]), 1);
        chk("mis_fch", 64'(fch0), 1);
        chk("mis_fexp", 64'(fexp0), 12);
        chk("mis_fgot", 64'(fgot0), 99);

        // Timeout on ch2, boundary at 7 idle cycles, strobe-wins at the 8th.
        do_reset();
        drive(4'b0100, pk(2, 50));
        idle(7);
        chk("to_pre_locked2", 64'(lk0[2]), 1);
        chk("to_pre_sticky", 64'(ts0), 0);
        idle(1);
        chk("to_sticky2", 64'(ts0[2]), 1);
        chk("to_err", 64'(e0), 1);
        chk("to_locked2", 64'(lk0[2]), 0);
        drive(4'b0100, pk(2, 200));
        chk("to_relock", 64'(lk0[2]), 1);
        chk("to_relock_err", 64'(e0), 1);
        idle(7);
        drive(4'b0100, pk(2, 201));
        chk("to_race_err", 64'(e0), 1);
        chk("to_race_locked", 64'(lk0[2]), 1);

        // All four channels at once, ch0 and ch3 mismatch.
        do_reset();
        drive(4'hF, {8'd40, 8'd30, 8'd20, 8'd10});
        drive(4'hF, {8'd88, 8'd31, 8'd21, 8'd77});
        chk("all_xfer", 64'(x0), 8);
        chk("all_err", 64'(e0), 2);
        chk("all_fch", 64'(fch0), 0);
        chk("all_fexp", 64'(fexp0), 11);
        chk("all_sticky", 64'(es0), 64'h9);

        // Saturation and clear.
        do_reset();
        for (int k = 0; k < 20; k++) drive(4'b0001, pk(0, k));
        chk("sat_xfer", 64'(x0), 15);
        chk("sat_err0", 64'(e0), 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_xfer", 64'(x0), 0);
        chk("clr_locked", 64'(lk0[0]), 1);
        for (int k = 0; k < 20; k++) drive(4'b0001, pk(0, 3));
        chk("sat_err", 64'(e0), 15);
        chk("sat_xfer2", 64'(x0), 15);

        // 8-bit wrap and enable freeze.
        do_reset();
        drive(4'b0001, pk(0, 8'hFF)); drive(4'b0001, pk(0, 8'h00));
        chk("wrap_err", 64'(e0), 0);
        en = 1'b0;
        drive(4'b0001, pk(0, 5));
        idle(10);
        chk("en_xfer", 64'(x0), 2);
        chk("en_to", 64'(ts0), 0);
        en = 1'b1;
        drive(4'b0001, pk(0, 1));
        chk("en_resume_err", 64'(e0), 0);
        chk("en_resume_xfer", 64'(x0), 3);

        // Strobe coincident with reset is discarded.
        rst = 1'b1; strobe0 = 4'b0010; data0 = pk(1, 77);
        @(negedge clk);
        rst = 1'b0; strobe0 = '0;
        chk("rst_strobe_locked", 64'(lk0), 0);
        chk("rst_strobe_xfer", 64'(x0), 0);
        drive(4'b0010, pk(1, 77)); drive(4'b0010, pk(1, 78));
        chk("rst_reseed_err", 64'(e0), 0);
        chk("rst_reseed_lock", 64'(lk0[1]), 1);

        // LFSR mode, 8-bit truncated POLY = 0x03.
        for (int k = 0; k < 11; k++) drive1(lfsr_seq[k]);
        chk("lfsr_xfer", 64'(x1), 11);
        chk("lfsr_err", 64'(e1), 0);
        chk("lfsr_locked", 64'(lk1), 1);
        drive1(8'd25);
        chk("lfsr_mis_err", 64'(e1), 1);
        chk("lfsr_fexp", 64'(fexp1), 24);
        chk("lfsr_fgot", 64'(fgot1), 25);
        repeat (20) @(negedge clk);
        chk("lfsr_no_to", 64'(lk1), 1);
        chk("lfsr_ts", 64'(ts1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
